// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types for the writeback port arbiter (register address, data word, pending entry, FSM state)
package wb_arb_pkg;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    word_t     data;
  } pend_entry_t;
  typedef enum logic {NORMAL, FORCE} arb_state_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback / long-latency / hazard / register-file signals of the write-port arbiter
//   master: pipeline + long-latency unit + register file side; slave: the arbiter
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;
  logic      RegWriteW;
  reg_addr_t RdW;
  word_t     ResultW;
  logic      LuValid;
  reg_addr_t LuRd;
  word_t     LuData;
  logic      LuReady;
  reg_addr_t Rs1D;
  reg_addr_t Rs2D;
  logic      PendHitD;
  logic      StallW;
  logic      RegWriteOut;
  reg_addr_t RdOut;
  word_t     DataOut;
  modport master (
    output RegWriteW, RdW, ResultW, LuValid, LuRd, LuData, Rs1D, Rs2D,
    input  LuReady, PendHitD, StallW, RegWriteOut, RdOut, DataOut
  );
  modport slave (
    input  RegWriteW, RdW, ResultW, LuValid, LuRd, LuData, Rs1D, Rs2D,
    output LuReady, PendHitD, StallW, RegWriteOut, RdOut, DataOut
  );
endinterface

// File: rtl/wb_port_arbiter_pend_fifo.sv
// pend_fifo: pending long-latency results with per-entry valid (WAW squash) and source-register compare vector
//   i_push/i_push_rd/i_push_data: enqueue; i_pop: drop head; i_sq_en/i_sq_rd: clear matching entries
//   i_rs1/i_rs2: decode sources; o_hit: per-entry match (popped head excluded); o_head/o_empty/o_full: status
module pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  reg_addr_t        i_push_rd,
  input  word_t            i_push_data,
  input  logic             i_pop,
  input  logic             i_sq_en,
  input  reg_addr_t        i_sq_rd,
  input  reg_addr_t        i_rs1,
  input  reg_addr_t        i_rs2,
  output pend_entry_t      o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [DEPTH-1:0] o_hit
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  pend_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_cnt;
  // later assignments win: a pushed entry is never squashed, and a popped slot
  // loses its valid bit so stale entries never raise a hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_sq_en && r_mem[i].rd == i_sq_rd) r_mem[i].valid <= 1'b0;
      if (i_pop) begin
        r_mem[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (i_push) begin
        r_mem[r_wr_ptr] <= '{valid: 1'b1, rd: i_push_rd, data: i_push_data};
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  always_comb begin
    o_hit = '0;
    for (int i = 0; i < DEPTH; i++)
      o_hit[i] = r_mem[i].valid && !(i_pop && r_rd_ptr == AW'(i)) &&
                 ((i_rs1 != '0 && r_mem[i].rd == i_rs1) || (i_rs2 != '0 && r_mem[i].rd == i_rs2));
  end
  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback (priority) and buffered long-latency results
//   clk, rst (async, active-low); bus: slave modport carrying writeback, long-latency, hazard and write-port signals
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);
  arb_state_t       r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  pend_entry_t      w_head;
  logic             w_empty, w_full, w_stall, w_pipe_wr, w_pop, w_drain_wr, w_ready, w_push, w_new_hit;
  logic [DEPTH-1:0] w_hit;
  pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst),
    .i_push(w_push), .i_push_rd(bus.LuRd), .i_push_data(bus.LuData),
    .i_pop(w_pop), .i_sq_en(w_pipe_wr), .i_sq_rd(bus.RdW),
    .i_rs1(bus.Rs1D), .i_rs2(bus.Rs2D),
    .o_head(w_head), .o_empty(w_empty), .o_full(w_full), .o_hit(w_hit)
  );
  // every output is gated by rst so reset takes effect without a clock edge
  always_comb begin
    w_stall    = rst && r_state == FORCE;
    w_pipe_wr  = rst && bus.RegWriteW && bus.RdW != '0 && !w_stall;
    w_pop      = rst && !w_empty && !w_pipe_wr;
    w_drain_wr = w_pop && w_head.valid;
    w_ready    = rst && (!w_full || w_pop);
    w_push     = bus.LuValid && w_ready && bus.LuRd != '0;
    w_new_hit  = w_push && ((bus.Rs1D != '0 && bus.LuRd == bus.Rs1D) || (bus.Rs2D != '0 && bus.LuRd == bus.Rs2D));
  end
  assign bus.StallW      = w_stall;
  assign bus.LuReady     = w_ready;
  assign bus.PendHitD    = rst && (|w_hit || w_new_hit);
  assign bus.RegWriteOut = w_pipe_wr || w_drain_wr;
  assign bus.RdOut       = w_pipe_wr ? bus.RdW : w_drain_wr ? w_head.rd : '0;
  assign bus.DataOut     = w_pipe_wr ? bus.ResultW : w_drain_wr ? w_head.data : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= NORMAL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // the head has waited STARVE_LIMIT cycles once the incremented count reaches the limit
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = r_cnt + 4'd1;
    if (r_state == FORCE) begin
      w_state_nxt = NORMAL;
      w_cnt_nxt   = '0;
    end else if (w_pop) begin
      w_cnt_nxt = '0;
    end else if (!w_empty) begin
      w_cnt_nxt   = w_cnt_inc;
      w_state_nxt = (w_cnt_inc == 4'(STARVE_LIMIT)) ? FORCE : NORMAL;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4)
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;
  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    total = 0;
  int    bad = 0;
  word_t rf [32];
  wb_port_arbiter_if bus ();
  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (rst && bus.RegWriteOut) rf[bus.RdOut] <= bus.DataOut;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.RegWriteW = we;
    bus.RdW       = rd;
    bus.ResultW   = res;
    bus.LuValid   = lv;
    bus.LuRd      = lrd;
    bus.LuData    = ld;
    #1;
  endtask
  initial begin
    bus.Rs1D = 5'd7;
    bus.Rs2D = 5'd0;
    drive(1'b1, 5'd5, 32'hAAAA0001, 1'b1, 5'd7, 32'h1);
    #3;
    chk("rst_we", bus.RegWriteOut, 0);
    chk("rst_rd", bus.RdOut, 0);
    chk("rst_data", bus.DataOut, 0);
    chk("rst_stall", bus.StallW, 0);
    chk("rst_pend", bus.PendHitD, 0);
    chk("rst_ready", bus.LuReady, 0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.Rs1D = 5'd5;
    for (int c = 0; c < 10; c++) begin
      cyc();
      drive(1'b1, 5'd5, 32'hAAAA0001, 1'b0, 5'd0, 32'h0);
      chk("pipe_we", bus.RegWriteOut, 1);
      chk("pipe_rd", bus.RdOut, 5);
      chk("pipe_data", bus.DataOut, 32'hAAAA0001);
      chk("pipe_stall", bus.StallW, 0);
      chk("pipe_pend", bus.PendHitD, 0);
    end
    cyc();
    bus.Rs1D = 5'd7;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678);
    chk("idle_ready0", bus.LuReady, 1);
    chk("idle_pend0", bus.PendHitD, 1);
    chk("idle_we0", bus.RegWriteOut, 0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("idle_we1", bus.RegWriteOut, 1);
    chk("idle_rd1", bus.RdOut, 7);
    chk("idle_data1", bus.DataOut, 32'h12345678);
    chk("idle_pend1", bus.PendHitD, 0);
    chk("idle_ready1", bus.LuReady, 1);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("idle_we2", bus.RegWriteOut, 0);
    chk("idle_rd2", bus.RdOut, 0);
    cyc();
    bus.Rs1D = 5'd9;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    chk("starve_rd0", bus.RdOut, 3);
    chk("starve_pend0", bus.PendHitD, 1);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
      chk("starve_stall", bus.StallW, 32'(c == 5));
      chk("starve_we", bus.RegWriteOut, 1);
      chk("starve_rd", bus.RdOut, (c == 5) ? 32'd9 : 32'd3);
      chk("starve_data", bus.DataOut, (c == 5) ? 32'h99 : 32'h33);
      chk("starve_pend", bus.PendHitD, 32'(c < 5));
    end
    for (int c = 0; c < 16; c++) begin
      cyc();
      drive(1'b1, 5'd3, 32'h33, c <= 5, (c == 0) ? 5'd10 : (c == 1) ? 5'd11 : 5'd12,
            (c == 0) ? 32'hA0 : (c == 1) ? 32'hB0 : 32'hC0);
      chk("full_ready", bus.LuReady, 32'(c < 2 || c == 5 || c >= 10));
      chk("full_stall", bus.StallW, 32'(c == 5 || c == 10 || c == 15));
      chk("full_rd", bus.RdOut, (c == 5) ? 32'd10 : (c == 10) ? 32'd11 : (c == 15) ? 32'd12 : 32'd3);
      chk("full_data", bus.DataOut, (c == 5) ? 32'hA0 : (c == 10) ? 32'hB0 : (c == 15) ? 32'hC0 : 32'h33);
    end
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("full_empty", bus.RegWriteOut, 0);
    cyc();
    bus.Rs1D = 5'd4;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    chk("waw_rd0", bus.RdOut, 3);
    cyc();
    drive(1'b1, 5'd4, 32'hBEEF, 1'b0, 5'd0, 32'h0);
    chk("waw_rd1", bus.RdOut, 4);
    chk("waw_data1", bus.DataOut, 32'hBEEF);
    chk("waw_pend1", bus.PendHitD, 1);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("waw_drain_we", bus.RegWriteOut, 0);
    chk("waw_pend2", bus.PendHitD, 0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("waw_rf4", rf[4], 32'hBEEF);
    chk("waw_empty", bus.RegWriteOut, 0);
    cyc();
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h60);
    chk("same_rd0", bus.RdOut, 6);
    chk("same_data0", bus.DataOut, 32'h66);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("same_we1", bus.RegWriteOut, 1);
    chk("same_rd1", bus.RdOut, 6);
    chk("same_data1", bus.DataOut, 32'h60);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("same_rf6", rf[6], 32'h60);
    cyc();
    bus.Rs1D = 5'd8;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    end
    chk("ar_stall_pre", bus.StallW, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_stall", bus.StallW, 0);
    chk("ar_we", bus.RegWriteOut, 0);
    chk("ar_ready", bus.LuReady, 0);
    chk("ar_rd", bus.RdOut, 0);
    chk("ar_pend", bus.PendHitD, 0);
    #1;
    rst = 1'b1;
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("ar_post_we", bus.RegWriteOut, 0);
    chk("ar_post_pend", bus.PendHitD, 0);
    chk("ar_post_ready", bus.LuReady, 1);
    chk("ar_post_stall", bus.StallW, 0);
    cyc();
    chk("ar_post_we2", bus.RegWriteOut, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage and a long-latency result source, such as a multiply/divide unit or a load-return unit.
- Pipeline writeback has priority. Long-latency results are buffered in a small FIFO and drained into idle writeback slots.
- Forces a pipeline stall when a buffered result has waited too long.
- Exports a pending-register hit so the hazard logic can stall decode on registers still waiting to be written.

Parameters:
- DEPTH, 2: number of pending-result FIFO entries; power of two, 2..8.
- STARVE_LIMIT, 4: cycles the FIFO head may wait before a forced bubble is requested; 1..15.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous reset, active-low.
- RegWriteW  in  1  writeback stage requests a register write.
- RdW  in  5  writeback destination register.
- ResultW  in  32  writeback result (writeback mux output).
- LuValid  in  1  long-latency unit presents a result.
- LuRd  in  5  long-latency unit destination register.
- LuData  in  32  long-latency unit result.
- LuReady  out  1  FIFO can accept; a transfer occurs when LuValid and LuReady are both 1.
- Rs1D  in  5  decode source register 1, for the pending check.
- Rs2D  in  5  decode source register 2, for the pending check.
- PendHitD  out  1  Rs1D or Rs2D matches a valid FIFO entry; x0 never matches.
- StallW  out  1  freeze the pipeline this cycle; writeback inputs are held.
- RegWriteOut  out  1  register-file write enable.
- RdOut  out  5  register-file write address.
- DataOut  out  32  register-file write data.

Behaviour:
Reset (rst = 0, asynchronous):
- FIFO empty, pointers 0, wait counter 0, state NORMAL.
- RegWriteOut = 0, StallW = 0, PendHitD = 0, LuReady = 0.
- RdOut and DataOut = 0.

Write port (combinational, zero latency):
- A pipeline write is valid when RegWriteW = 1, RdW != 0 and StallW = 0. A pipeline write is never delayed.
- If the pipeline write is valid, it wins: RdOut = RdW, DataOut = ResultW.
- Otherwise, if the FIFO is non-empty, the head drains: RegWriteOut = 1, head rd/data are driven, and the head pops at the edge.
- Otherwise RegWriteOut = 0, and RdOut/DataOut = 0.

Enqueue:
- LuReady = not full OR popping this cycle. A push into a full FIFO on the same cycle as a pop is accepted.
- LuValid with LuRd = 0 is accepted and discarded: no entry is created.
- LuValid with LuReady = 0 holds; LuRd and LuData stay stable until accepted.

WAW squash:
- A valid pipeline write whose RdW matches a valid FIFO entry clears that entry's valid bit at the edge. The pipeline write is younger.
- Squashed entries remain in the FIFO. They pop without writing: RegWriteOut = 0 on that drain cycle.
- An entry accepted in the same cycle as a matching pipeline write is not squashed.

State machine (starvation), counter cnt, 4 bits:
- NORMAL:
  - cnt increments each cycle the FIFO is non-empty and the head is not popped.
  - cnt clears on pop.
  - When cnt = STARVE_LIMIT, go to FORCE.
- FORCE:
  - StallW = 1 for exactly one cycle; the head drains that cycle.
  - Return to NORMAL with cnt = 0.
- StallW is a registered-state decode, free of combinational loops on RegWriteW.

PendHitD:
- Combinational compare of Rs1D and Rs2D against the rd of every valid entry.
- Includes the entry being accepted this cycle.
- Excludes an entry being popped this cycle.

Reset mid-operation:
- Pending entries are lost.
- The outputs reach their reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package wb_arb_pkg:
  - typedef reg_addr_t (5 bits) and word_t (32 bits).
  - struct pend_entry_t {valid, rd, data}.
  - enum arb_state_t {NORMAL, FORCE}.
- One natural sub-module: pend_fifo (DEPTH entries, per-entry valid and squash, rd compare vector). The arbiter and FSM stay in wb_port_arbiter.

Test Plan:
- Pipeline-only traffic: RegWriteW = 1, RdW = 5, ResultW = 0xAAAA0001 for 10 cycles -> RegWriteOut = 1, RdOut = 5 every cycle; StallW and PendHitD stay 0.
- Idle-slot drain: LuValid pushes rd = 7, data = 0x12345678 while RegWriteW = 0 -> written on the next cycle; LuReady stays 1; PendHitD = 1 with Rs1D = 7 for exactly that cycle.
- Starvation: RegWriteW held at 1 (RdW = 3) with one pending rd = 9 and STARVE_LIMIT = 4 ->
  - StallW = 1 on the 5th cycle after the push; rd = 9 is written that cycle.
  - RdW = 3 is written the following cycle.
- Full FIFO: fill DEPTH = 2 entries while the pipeline writes every cycle -> LuReady = 0 and the third LuValid holds until the forced drain; no data is lost; written order is FIFO.
- WAW squash: pending rd = 4, then pipeline writes rd = 4 with 0xBEEF -> the entry drains with RegWriteOut = 0; the register-file model holds 0xBEEF.
- Async reset during a FORCE cycle: deassert and reassert rst mid-cycle -> StallW, RegWriteOut and LuReady are 0 immediately; the FIFO is empty afterwards.
